xcorr_peak_engine: RTL

Parametrised sliding-window cross-correlator for N sample channels that also locates the correlation peak of every channel pair. It sits after the ADC sample-collection stage and feeds the direction-of-arrival logic. Relative to the fixed 4-channel correlator it adds:
- a configurable channel count, window length and lag range;
- an explicit ready/valid input handshake with overrun detection;
- a synchronous clear;
- a sequential per-pair argmax search, so downstream logic no longer scans the full lag vectors.

---
 rtl/xcorr_peak_engine.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/xcorr_peak_engine.sv
// Sliding-window cross-correlator over every channel pair, followed by a
// sequential argmax search that reports the peak lag and value per pair.
module xcorr_peak_engine #(
    parameter int NUM_CHANNELS        = 4,
    parameter int NUM_BITS_SAMPLE     = 12,
    parameter int WINDOW_LEN          = 1024,
    parameter int MAX_LAG             = 11,
    parameter int NUM_BITS_XCORR      = 32,
    parameter int INPUT_OFFSET_BINARY = 1,
    localparam int NUM_PAIRS          = NUM_CHANNELS * (NUM_CHANNELS - 1) / 2,
    localparam int NUM_LAGS           = 2 * MAX_LAG + 1,
    localparam int LAG_W              = $clog2(MAX_LAG + 1) + 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         clear,
    input  logic                                         sample_valid,
    input  logic [NUM_CHANNELS*NUM_BITS_SAMPLE-1:0]      sample_data,
    output logic                                         in_ready,
    output logic                                         out_valid,
    output logic [NUM_PAIRS*NUM_LAGS*NUM_BITS_XCORR-1:0] xcorr_data,
    output logic [NUM_PAIRS*LAG_W-1:0]                   peak_lag,
    output logic [NUM_PAIRS*NUM_BITS_XCORR-1:0]          peak_value,
    output logic                                         window_full,
    output logic                                         overrun
);

    localparam int B        = NUM_BITS_SAMPLE;
    localparam int W        = NUM_BITS_XCORR;
    localparam int L        = MAX_LAG;
    localparam int DEPTH    = WINDOW_LEN + 2 * L + 1;
    localparam int FULL_CNT = WINDOW_LEN + 2 * L;
    localparam int CNT_W    = $clog2(FULL_CNT + 1);
    localparam int K_W      = $clog2(NUM_LAGS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_SEARCH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                overrun_q, overrun_d;
    logic                out_valid_q, out_valid_d;
    logic                load_peak;
    logic                accept;

    logic signed [B-1:0]     buf_q      [NUM_CHANNELS][DEPTH];
    logic signed [W-1:0]     acc_q      [NUM_PAIRS][NUM_LAGS];
    logic signed [W-1:0]     acc_d      [NUM_PAIRS][NUM_LAGS];
    logic signed [W-1:0]     best_val_q [NUM_PAIRS];
    logic signed [W-1:0]     best_val_d [NUM_PAIRS];
    logic [K_W-1:0]          best_k_q   [NUM_PAIRS];
    logic [K_W-1:0]          best_k_d   [NUM_PAIRS];
    logic signed [W-1:0]     peak_val_q [NUM_PAIRS];
    logic signed [LAG_W-1:0] peak_lag_q [NUM_PAIRS];
    logic signed [LAG_W-1:0] peak_lag_d [NUM_PAIRS];

    function automatic logic signed [B-1:0] to_twos(input logic [B-1:0] raw);
        logic [B-1:0] msb;
        msb        = '0;
        msb[B-1]   = 1'b1;
        if (INPUT_OFFSET_BINARY != 0) return $signed(raw ^ msb);
        return $signed(raw);
    endfunction

    function automatic logic signed [W-1:0] prod_ext(input logic signed [B-1:0] a,
                                                     input logic signed [B-1:0] b);
        logic signed [2*B-1:0] p;
        p = (2*B)'(a) * (2*B)'(b);
        return W'(p);
    endfunction

    assign in_ready = (state_q == S_IDLE);
    assign accept   = sample_valid && in_ready && !clear;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        out_valid_d = 1'b0;
        load_peak   = 1'b0;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_UPDATE;
            S_UPDATE: begin
                state_d = S_SEARCH;
                k_d     = '0;
            end
            S_SEARCH: begin
                k_d = k_q + K_W'(1);
                if (k_q == K_W'(NUM_LAGS - 1)) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    load_peak   = 1'b1;
                end
            end
            default:  state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d     = S_IDLE;
            k_d         = '0;
            out_valid_d = 1'b0;
            load_peak   = 1'b0;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        overrun_d = overrun_q | (sample_valid & ~in_ready);
        if (accept && cnt_q != CNT_W'(FULL_CNT)) cnt_d = cnt_q + CNT_W'(1);
        if (clear) begin
            cnt_d     = '0;
            overrun_d = 1'b0;
        end
    end

    // Running window sum: add the newest product, retire the one leaving the window.
    always_comb begin
        for (int p = 0; p < NUM_PAIRS; p++)
            for (int k = 0; k < NUM_LAGS; k++)
                acc_d[p][k] = acc_q[p][k];
        if (state_q == S_UPDATE) begin
            for (int i = 0; i < NUM_CHANNELS; i++)
                for (int j = i + 1; j < NUM_CHANNELS; j++)
                    for (int k = 0; k < NUM_LAGS; k++)
                        acc_d[i*NUM_CHANNELS - i*(i+1)/2 + (j-i-1)][k] =
                            acc_q[i*NUM_CHANNELS - i*(i+1)/2 + (j-i-1)][k]
                            + prod_ext(buf_q[i][L], buf_q[j][k])
                            - prod_ext(buf_q[i][L+WINDOW_LEN], buf_q[j][k+WINDOW_LEN]);
        end
        if (clear) begin
            for (int p = 0; p < NUM_PAIRS; p++)
                for (int k = 0; k < NUM_LAGS; k++)
                    acc_d[p][k] = '0;
        end
    end

    // Strict '>' keeps the lowest lag index on ties.
    always_comb begin
        for (int p = 0; p < NUM_PAIRS; p++) begin
            best_val_d[p] = best_val_q[p];
            best_k_d[p]   = best_k_q[p];
            if (state_q == S_SEARCH &&
                (k_q == '0 || acc_q[p][k_q] > best_val_q[p])) begin
                best_val_d[p] = acc_q[p][k_q];
                best_k_d[p]   = k_q;
            end
            peak_lag_d[p] = LAG_W'(int'(best_k_d[p]) - L);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++)
                for (int d = 0; d < DEPTH; d++)
                    buf_q[c][d] <= '0;
        end else if (clear) begin
            for (int c = 0; c < NUM_CHANNELS; c++)
                for (int d = 0; d < DEPTH; d++)
                    buf_q[c][d] <= '0;
        end else if (accept) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int d = DEPTH - 1; d > 0; d--)
                    buf_q[c][d] <= buf_q[c][d-1];
                buf_q[c][0] <= to_twos(sample_data[c*B +: B]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PAIRS; p++) begin
                for (int k = 0; k < NUM_LAGS; k++)
                    acc_q[p][k] <= '0;
                best_val_q[p] <= '0;
                best_k_q[p]   <= '0;
                peak_val_q[p] <= '0;
                peak_lag_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PAIRS; p++) begin
                for (int k = 0; k < NUM_LAGS; k++)
                    acc_q[p][k] <= acc_d[p][k];
                best_val_q[p] <= best_val_d[p];
                best_k_q[p]   <= best_k_d[p];
                if (clear) begin
                    peak_val_q[p] <= '0;
                    peak_lag_q[p] <= '0;
                end else if (load_peak) begin
                    peak_val_q[p] <= best_val_d[p];
                    peak_lag_q[p] <= peak_lag_d[p];
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign overrun     = overrun_q;
    assign window_full = (cnt_q == CNT_W'(FULL_CNT));

    for (genvar gp = 0; gp < NUM_PAIRS; gp++) begin : g_pair
        for (genvar gk = 0; gk < NUM_LAGS; gk++) begin : g_lag
            assign xcorr_data[(gp*NUM_LAGS+gk)*W +: W] = acc_q[gp][gk];
        end
        assign peak_lag[gp*LAG_W +: LAG_W] = peak_lag_q[gp];
        assign peak_value[gp*W +: W]       = peak_val_q[gp];
    end

endmodule
